// File: rtl/detect_event_logger.sv
// detect_event_logger
// Sits behind the serial pattern detector. On each detection it stores a
// record made of a free-running timestamp and the most recent WIN input bits.
// Records go into a small FIFO that a consumer drains over valid/ready.
// Detections that arrive while the FIFO is full are dropped and counted.
module detect_event_logger #(
    parameter int WIN   = 8,
    parameter int TS_W  = 16,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_bit,
    input  logic                 det,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [TS_W+WIN-1:0]  rec_data,
    output logic                 overflow,
    output logic [7:0]           drop_cnt,
    input  logic                 clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = TS_W + WIN;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIN-1:0]  hist_reg;
    logic [WIN-1:0]  hist_next;
    logic [TS_W-1:0] ts_reg;
    logic [RW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW:0]     count_reg;
    logic [AW:0]     count_next;
    logic            overflow_reg;
    logic [7:0]      drop_cnt_reg;
    logic [7:0]      drop_cnt_inc;

    logic full;
    logic pop;
    logic push;
    logic drop;

    // History including the bit sampled at this edge; this is what a record captures.
    assign hist_next = {hist_reg[WIN-2:0], in_bit};

    // rec_valid depends only on the count register, so rec_ready never reaches it combinationally.
    assign full      = (count_reg == FULL_COUNT);
    assign rec_valid = (count_reg != '0);
    assign pop       = rec_valid & rec_ready;
    // A full FIFO that is being popped in the same cycle still has room for the new record.
    assign push      = det & (~full | pop);
    assign drop      = det & full & ~pop;

    assign drop_cnt_inc = (drop_cnt_reg == 8'hFF) ? drop_cnt_reg : drop_cnt_reg + 8'd1;

    assign overflow = overflow_reg;
    assign drop_cnt = drop_cnt_reg;

    // Head record is forced to zero whenever the FIFO is empty, so stale storage never shows.
    assign rec_data = rec_valid ? mem[rd_ptr_reg] : '0;

    // Occupancy update: simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Record storage; contents need no reset because the output is gated by rec_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {ts_reg, hist_next};
        end
    end

    // History shift register, timestamp counter and FIFO pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_reg   <= '0;
            ts_reg     <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            hist_reg  <= hist_next;
            ts_reg    <= ts_reg + TS_W'(1);
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
        end
    end

    // Overflow flag and saturating drop counter; a drop in the clear cycle restarts the count at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
            drop_cnt_reg <= clr_ovf ? 8'd1 : drop_cnt_inc;
        end else if (clr_ovf) begin
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end
    end

endmodule

// File: tb/tb_detect_event_logger.sv
// Testbench for detect_event_logger: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_detect_event_logger;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_bit = 1'b0;
    logic        det = 1'b0;
    logic        rec_ready = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        rec_valid;
    logic [23:0] rec_data;
    logic        overflow;
    logic [7:0]  drop_cnt;

    // Second instance with a 4-bit timestamp to exercise wrap-around.
    logic        det2 = 1'b0;
    logic        ready2 = 1'b0;
    logic        clr2 = 1'b0;
    logic        rec_valid2;
    logic [11:0] rec_data2;
    logic        overflow2;
    logic [7:0]  drop_cnt2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    detect_event_logger #(.WIN(8), .TS_W(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_bit(in_bit), .det(det),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
        .overflow(overflow), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
    );

    detect_event_logger #(.WIN(8), .TS_W(4), .DEPTH(4)) dut_ts4 (
        .clk(clk), .rst(rst), .in_bit(in_bit), .det(det2),
        .rec_valid(rec_valid2), .rec_ready(ready2), .rec_data(rec_data2),
        .overflow(overflow2), .drop_cnt(drop_cnt2), .clr_ovf(clr2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [23:0] m_q[$];
    logic [15:0] m_ts = '0;
    logic [7:0]  m_hist = '0;
    bit          m_ovf = 1'b0;
    int          m_drops = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_ts = '0;
            m_hist = '0;
            m_ovf = 1'b0;
            m_drops = 0;
        end else begin
            bit do_pop;
            logic [23:0] rec;
            m_hist = {m_hist[6:0], in_bit};
            rec = {m_ts, m_hist};
            do_pop = (m_q.size() > 0) && rec_ready;
            if (do_pop) void'(m_q.pop_front());
            if (det) begin
                if (m_q.size() < 4) begin
                    m_q.push_back(rec);
                end else begin
                    m_ovf = 1'b1;
                    m_drops = clr_ovf ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
                end
            end else if (clr_ovf) begin
                m_ovf = 1'b0;
                m_drops = 0;
            end
            m_ts = m_ts + 16'd1;
        end
    end

    // Per-cycle comparison on the falling edge, away from input changes and active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [23:0] exp_data;
            exp_data = (m_q.size() > 0) ? m_q[0] : 24'h0;
            check("model_valid", 32'(rec_valid), 32'(m_q.size() > 0));
            check("model_data", 32'(rec_data), 32'(exp_data));
            check("model_ovf", 32'(overflow), 32'(m_ovf));
            check("model_drops", 32'(drop_cnt), 32'(m_drops));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Drive inputs (we are 1 time unit after an edge) and advance past the next edge.
    task automatic step(input logic b, input logic d, input logic r, input logic c);
        in_bit = b; det = d; rec_ready = r; clr_ovf = c;
        @(posedge clk);
        #1;
        $display("step in=%0b det=%0b rdy=%0b clr=%0b -> valid=%0b data=%06h ovf=%0b drops=%0d",
                 b, d, r, c, rec_valid, rec_data, overflow, drop_cnt);
    endtask

    // Reset asserted mid-cycle; released 1 unit after the following edge.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        in_bit = 0; det = 0; rec_ready = 0; clr_ovf = 0; det2 = 0; ready2 = 0;
        #1;
        check("rst_valid", 32'(rec_valid), 32'd0);
        check("rst_data", 32'(rec_data), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_drops", 32'(drop_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        chk_en = 1'b1;

        // 1: capture with history, then hold while not ready
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        check("t1_valid", 32'(rec_valid), 32'd1);
        check("t1_data", 32'(rec_data), 32'h00030B);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0);
            check("t1_hold", 32'(rec_data), 32'h00030B);
        end

        // 2: six detections into a depth-4 FIFO, then drain in order
        do_reset();
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
        check("t2_ovf", 32'(overflow), 32'd1);
        check("t2_drops", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 4; i++) begin
            check("t2_order", 32'(rec_data[23:8]), 32'(i));
            step(0, 0, 1, 0);
        end
        check("t2_empty_valid", 32'(rec_valid), 32'd0);
        check("t2_empty_data", 32'(rec_data), 32'd0);

        // 3: full FIFO with simultaneous pop and push
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        check("t3_drops", 32'(drop_cnt), 32'd0);
        check("t3_head", 32'(rec_data[23:8]), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            check("t3_order", 32'(rec_data[23:8]), 32'(i));
            step(0, 0, 1, 0);
        end
        check("t3_empty", 32'(rec_valid), 32'd0);

        // 4: drop counter saturation, clear, clear coincident with drop
        do_reset();
        for (int i = 0; i < 304; i++) step(0, 1, 0, 0);
        check("t4_sat", 32'(drop_cnt), 32'd255);
        step(0, 0, 0, 1);
        check("t4_clr_drops", 32'(drop_cnt), 32'd0);
        check("t4_clr_ovf", 32'(overflow), 32'd0);
        step(0, 1, 0, 1);
        check("t4_race_ovf", 32'(overflow), 32'd1);
        check("t4_race_drops", 32'(drop_cnt), 32'd1);

        // 5: 4-bit timestamp wraps from 15 to 0
        do_reset();
        for (int e = 0; e <= 16; e++) begin
            det2 = (e == 15 || e == 16);
            step(0, 0, 0, 0);
        end
        det2 = 0;
        check("t5_valid", 32'(rec_valid2), 32'd1);
        check("t5_ts15", 32'(rec_data2[11:8]), 32'd15);
        ready2 = 1;
        step(0, 0, 0, 0);
        ready2 = 0;
        check("t5_ts0", 32'(rec_data2[11:8]), 32'd0);
        check("t5_valid2", 32'(rec_valid2), 32'd1);

        // 6: asynchronous reset with records buffered, then post-reset capture
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        check("t6_pre_valid", 32'(rec_valid), 32'd1);
        do_reset();
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        check("t6_first", 32'(rec_data), 32'h000102);

        step(0, 0, 0, 0);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
